// File: rtl/gbe_rx_udp_demux.sv
// gbe_rx_udp_demux
//   Byte-wide GbE receive parser/filter on the MAC side of the link. It walks
//   Ethernet / IPv4 (with options) / UDP headers and matches the UDP
//   destination port against a table of N_PORTS entries. Payload of accepted
//   frames is forwarded, tagged with the index of the matching entry. Every
//   frame that starts produces exactly one descriptor, which carries the
//   payload length, the source address/port and a drop-reason code.
//
//   Ports
//     mac_clk, mac_rst        clock, synchronous active-high reset
//     mac_rx_*                MAC rx byte stream plus FCS good/bad pulses
//     local_enable/mac/ip     station identity; enable is sampled at frame start
//     port_table, port_en     UDP port match entries (entry i at [16i+15:16i])
//     out_*                   payload stream (2-cycle latency) with sof/eof/chan
//     desc_*                  one-cycle per-frame descriptor strobe and fields
//
//   Reason codes: 0 ok, 1 MAC/enable, 2 ethertype/version/IHL, 3 protocol or
//   fragment, 4 dst IP, 5 no port match, 6 bad FCS or status timeout,
//   7 runt or length saturation.
//
//   Optional: define GBE_RX_VLAN_EN to accept 802.1Q tagged frames. The VID
//   then appears on desc_vlan (0 when untagged). Undefined, 0x8100 is code 2.
module gbe_rx_udp_demux #(
    parameter int N_PORTS        = 4,
    parameter int CHAN_W         = 2,
    parameter int LEN_W          = 11,
    parameter int STATUS_TIMEOUT = 16
) (
    input  logic                   mac_clk,
    input  logic                   mac_rst,
    input  logic [7:0]             mac_rx_data,
    input  logic                   mac_rx_dvld,
    input  logic                   mac_rx_goodframe,
    input  logic                   mac_rx_badframe,
    input  logic                   local_enable,
    input  logic [47:0]            local_mac,
    input  logic [31:0]            local_ip,
    input  logic [16*N_PORTS-1:0]  port_table,
    input  logic [N_PORTS-1:0]     port_en,
    output logic [7:0]             out_data,
    output logic                   out_dvld,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic [CHAN_W-1:0]      out_chan,
    output logic                   desc_valid,
    output logic                   desc_ok,
    output logic [2:0]             desc_reason,
    output logic [CHAN_W-1:0]      desc_chan,
    output logic [LEN_W-1:0]       desc_len,
    output logic [31:0]            desc_srcip,
    output logic [15:0]            desc_srcport
`ifdef GBE_RX_VLAN_EN
   ,output logic [11:0]            desc_vlan
`endif
);
    localparam int TMR_W = $clog2(STATUS_TIMEOUT + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    typedef enum logic [3:0] {
        S_GAP, S_IDLE, S_ETH, S_VLAN, S_IP, S_IPOPT, S_UDP, S_DATA, S_STATUS, S_DROP
    } state_t;

    state_t            state;
    logic [5:0]        cnt;       // byte index within the current header state
    logic [2:0]        reason;
    logic              en_q, uc_ok, bc_ok, ip_ok;
    logic [7:0]        hold;      // previous byte, for 16-bit fields
    logic [3:0]        ihl;
    logic [31:0]       srcip;
    logic [15:0]       srcport;
    logic [CHAN_W-1:0] chan;
    logic [LEN_W-1:0]  len;
    logic [TMR_W-1:0]  tmr;
    logic [7:0]        d1;
    logic              v1, sof1;
`ifdef GBE_RX_VLAN_EN
    logic [11:0]       vid;
`endif

    logic [7:0]        mac_b, ip_b;
    logic              hit;
    logic [CHAN_W-1:0] hit_idx;
    logic              take, start, hdr_state, ending, pulse, timeout;
    logic [2:0]        fin_code;
    logic [5:0]        opt_last;

    always_comb begin
        case (cnt[2:0])
            3'd0:    mac_b = local_mac[47:40];
            3'd1:    mac_b = local_mac[39:32];
            3'd2:    mac_b = local_mac[31:24];
            3'd3:    mac_b = local_mac[23:16];
            3'd4:    mac_b = local_mac[15:8];
            default: mac_b = local_mac[7:0];
        endcase
        case (cnt[1:0])   // dst IP sits at IP bytes 16..19
            2'd0:    ip_b = local_ip[31:24];
            2'd1:    ip_b = local_ip[23:16];
            2'd2:    ip_b = local_ip[15:8];
            default: ip_b = local_ip[7:0];
        endcase
    end

    // Scan from the top so the lowest enabled matching entry wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (port_en[i] && port_table[16*i +: 16] == {hold, mac_rx_data}) begin
                hit     = 1'b1;
                hit_idx = CHAN_W'(i);
            end
        end
    end

    assign take      = (state == S_DATA) && mac_rx_dvld && (len != LEN_MAX);
    assign start     = mac_rx_dvld && (state == S_IDLE || state == S_STATUS);
    assign hdr_state = (state == S_ETH) || (state == S_VLAN) || (state == S_IP) ||
                       (state == S_IPOPT) || (state == S_UDP);
    assign ending    = !mac_rx_dvld && (hdr_state || state == S_DATA || state == S_DROP);
    assign pulse     = mac_rx_goodframe || mac_rx_badframe;
    assign timeout   = (tmr == TMR_W'(STATUS_TIMEOUT - 1));
    // Only a goodframe pulse lets the parse result through; anything else is 6.
    assign fin_code  = (mac_rx_goodframe && !mac_rx_badframe) ? reason : 3'd6;
    assign opt_last  = {ihl, 2'b00} - 6'd21;

    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            state <= S_GAP;
            cnt <= '0; reason <= '0; en_q <= 1'b0; uc_ok <= 1'b0; bc_ok <= 1'b0;
            ip_ok <= 1'b0; hold <= '0; ihl <= '0; srcip <= '0; srcport <= '0;
            chan <= '0; len <= '0; tmr <= '0; d1 <= '0; v1 <= 1'b0; sof1 <= 1'b0;
            out_data <= '0; out_dvld <= 1'b0; out_sof <= 1'b0; out_eof <= 1'b0;
            out_chan <= '0; desc_valid <= 1'b0; desc_ok <= 1'b0; desc_reason <= '0;
            desc_chan <= '0; desc_len <= '0; desc_srcip <= '0; desc_srcport <= '0;
`ifdef GBE_RX_VLAN_EN
            vid <= '0; desc_vlan <= '0;
`endif
        end else begin
            desc_valid <= 1'b0;
            // Two-stage payload pipe: the byte is held one cycle so eof can be
            // set once we know the following byte will not be forwarded.
            d1       <= mac_rx_data;
            v1       <= take;
            sof1     <= take && (len == '0);
            out_data <= v1 ? d1 : 8'd0;
            out_dvld <= v1;
            out_sof  <= sof1;
            out_eof  <= v1 && !take;
            out_chan <= chan;
            hold     <= mac_rx_data;
            cnt      <= cnt + 6'd1;
            tmr      <= tmr + TMR_W'(1);
            if (take) len <= len + LEN_W'(1);

            if (ending) begin
                state <= S_STATUS;
                tmr   <= '0;
                if (hdr_state) reason <= 3'd7;
            end else begin
                case (state)
                    S_GAP: if (!mac_rx_dvld) state <= S_IDLE;
                    S_ETH: begin
                        if (cnt <= 6'd4) begin
                            uc_ok <= uc_ok && (mac_rx_data == mac_b);
                            bc_ok <= bc_ok && (mac_rx_data == 8'hff);
                        end
                        if (cnt == 6'd5 && (!en_q || !((uc_ok && mac_rx_data == mac_b) ||
                                                       (bc_ok && mac_rx_data == 8'hff)))) begin
                            reason <= 3'd1; state <= S_DROP;
                        end
                        if (cnt == 6'd13) begin
                            cnt <= '0;
                            if ({hold, mac_rx_data} == 16'h0800) state <= S_IP;
`ifdef GBE_RX_VLAN_EN
                            else if ({hold, mac_rx_data} == 16'h8100) state <= S_VLAN;
`endif
                            else begin reason <= 3'd2; state <= S_DROP; end
                        end
                    end
`ifdef GBE_RX_VLAN_EN
                    S_VLAN: begin   // TCI (2 B) then the real ethertype (2 B)
                        if (cnt == 6'd0) vid[11:8] <= mac_rx_data[3:0];
                        if (cnt == 6'd1) vid[7:0]  <= mac_rx_data;
                        if (cnt == 6'd3) begin
                            cnt <= '0;
                            if ({hold, mac_rx_data} == 16'h0800) state <= S_IP;
                            else begin reason <= 3'd2; state <= S_DROP; end
                        end
                    end
`endif
                    S_IP: begin
                        if (cnt == 6'd0) begin
                            ihl <= mac_rx_data[3:0];
                            if (mac_rx_data[7:4] != 4'd4 || mac_rx_data[3:0] < 4'd5) begin
                                reason <= 3'd2; state <= S_DROP;
                            end
                        end
                        // Flags/offset: MF is bit 5 of byte 6, offset spans 6[4:0]..7.
                        if (cnt == 6'd7 && (hold[5] || hold[4:0] != 5'd0 || mac_rx_data != 8'd0)) begin
                            reason <= 3'd3; state <= S_DROP;
                        end
                        if (cnt == 6'd9 && mac_rx_data != 8'h11) begin
                            reason <= 3'd3; state <= S_DROP;
                        end
                        if (cnt >= 6'd12 && cnt <= 6'd15) srcip <= {srcip[23:0], mac_rx_data};
                        if (cnt == 6'd16) ip_ok <= (mac_rx_data == ip_b);
                        if (cnt == 6'd17 || cnt == 6'd18) ip_ok <= ip_ok && (mac_rx_data == ip_b);
                        if (cnt == 6'd19) begin
                            cnt <= '0;
                            if (!(ip_ok && mac_rx_data == ip_b)) begin
                                reason <= 3'd4; state <= S_DROP;
                            end else begin
                                state <= (ihl == 4'd5) ? S_UDP : S_IPOPT;
                            end
                        end
                    end
                    S_IPOPT: if (cnt == opt_last) begin cnt <= '0; state <= S_UDP; end
                    S_UDP: begin
                        if (cnt <= 6'd1) srcport <= {srcport[7:0], mac_rx_data};
                        if (cnt == 6'd3) begin
                            if (hit) chan <= hit_idx;
                            else begin reason <= 3'd5; state <= S_DROP; end
                        end
                        if (cnt == 6'd7) state <= S_DATA;
                    end
                    // A byte arriving with the counter already saturated is dropped.
                    S_DATA: if (len == LEN_MAX) begin reason <= 3'd7; state <= S_DROP; end
                    S_STATUS: begin
                        if (pulse || mac_rx_dvld || timeout) begin
                            desc_valid   <= 1'b1;
                            desc_reason  <= fin_code;
                            desc_ok      <= (fin_code == 3'd0);
                            desc_chan    <= chan;
                            desc_len     <= len;
                            desc_srcip   <= srcip;
                            desc_srcport <= srcport;
`ifdef GBE_RX_VLAN_EN
                            desc_vlan    <= vid;
`endif
                            state        <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end

            // Frame start; also taken from STATUS, where it preempts the wait.
            // The current byte is byte 0 of the destination MAC.
            if (start) begin
                state   <= S_ETH;
                cnt     <= 6'd1;
                en_q    <= local_enable;
                uc_ok   <= (mac_rx_data == local_mac[47:40]);
                bc_ok   <= (mac_rx_data == 8'hff);
                reason  <= '0;
                chan    <= '0;
                len     <= '0;
                srcip   <= '0;
                srcport <= '0;
`ifdef GBE_RX_VLAN_EN
                vid     <= '0;
`endif
            end
        end
    end
endmodule
